player_bullet_controller: RTL and testbench

- Owns the player-bullet pool: spawns, moves and retires player bullets.
- Is the producer side of the collision path. Drives the per-slot bullet state and the packed {x[9:0], y[8:0]} positions that the collision logic consumes.
- Consumes the per-bullet collision flags returned by the collision logic and retires the flagged bullets.
- Sits between the player input/fire logic and the collision and render blocks.

---
 rtl/player_bullet_controller_if.sv | 25 ++
 rtl/player_bullet_controller.sv | 112 +++++++++++
 tb/tb_player_bullet_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/player_bullet_controller_if.sv
// Player-bullet bus: fire handshake, kill flags from collision, and the
// per-slot state/position view consumed by collision and render.
interface player_bullet_controller_if #(
  parameter int unsigned MAX_PLAYER_BULLET = 3
);
  logic [2:0]                      i_GameState;
  logic                            i_FrameTick;
  logic                            i_FireReq;
  logic                            o_FireAck;
  logic [9:0]                      i_PlayerPosition;
  logic [MAX_PLAYER_BULLET-1:0]    i_KillMask;
  logic [MAX_PLAYER_BULLET-1:0]    o_PlayerBulletState;
  logic [19*MAX_PLAYER_BULLET-1:0] o_PlayerBulletPosition;
  logic                            o_SlotsFull;

  modport master (
    input  i_GameState, i_FrameTick, i_FireReq, i_PlayerPosition, i_KillMask,
    output o_FireAck, o_PlayerBulletState, o_PlayerBulletPosition, o_SlotsFull
  );

  modport slave (
    output i_GameState, i_FrameTick, i_FireReq, i_PlayerPosition, i_KillMask,
    input  o_FireAck, o_PlayerBulletState, o_PlayerBulletPosition, o_SlotsFull
  );
endinterface

// File: rtl/player_bullet_controller.sv
// Player-bullet pool: spawns bullets on accepted fire requests, moves them
// upward each frame tick, and retires them on collision or at the top border.
module player_bullet_controller #(
  parameter int unsigned MAX_PLAYER_BULLET = 3,
  parameter logic [8:0]  PLAYER_CENTER_Y   = 9'd372,
  parameter logic [9:0]  PLAYER_WIDTH      = 10'd24,
  parameter logic [9:0]  BULLET_WIDTH      = 10'd4,
  parameter logic [8:0]  BULLET_HEIGHT     = 9'd16,
  parameter logic [8:0]  BULLET_SPEED      = 9'd4,
  parameter logic [3:0]  COOLDOWN_FRAMES   = 4'd8,
  parameter logic [2:0]  GAME_PLAYING      = 3'b001,
  parameter logic [18:0] NONE              = {10'd720, 9'd500}
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  player_bullet_controller_if.master  bus
);

  localparam logic [9:0] SPAWN_X_OFF = (PLAYER_WIDTH - BULLET_WIDTH) >> 1;
  localparam logic [8:0] SPAWN_Y     = PLAYER_CENTER_Y - BULLET_HEIGHT;
  localparam logic [9:0] NONE_X      = NONE[18:9];
  localparam logic [8:0] NONE_Y      = NONE[8:0];

  logic [MAX_PLAYER_BULLET-1:0] r_State;
  logic [9:0]                   r_PosX [MAX_PLAYER_BULLET];
  logic [8:0]                   r_PosY [MAX_PLAYER_BULLET];
  logic [3:0]                   r_Cooldown;
  logic                         r_FireAck;

  logic                         w_Playing;
  logic                         w_FreeFound;
  logic [MAX_PLAYER_BULLET-1:0] w_SpawnOH;
  logic                         w_FireAccept;
  logic [19*MAX_PLAYER_BULLET-1:0] w_PosBus;

  // Free-slot search sees only pre-edge state, so a slot retired this edge
  // cannot be reused until the next one.
  always_comb begin
    w_SpawnOH   = '0;
    w_FreeFound = 1'b0;
    for (int unsigned k = 0; k < MAX_PLAYER_BULLET; k++) begin
      if (!r_State[k] && !w_FreeFound) begin
        w_SpawnOH[k] = 1'b1;
        w_FreeFound  = 1'b1;
      end
    end
  end

  assign w_Playing    = (bus.i_GameState == GAME_PLAYING);
  assign w_FireAccept = bus.i_FireReq && (r_Cooldown == '0) && w_Playing && w_FreeFound;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State    <= '0;
      r_Cooldown <= '0;
      r_FireAck  <= 1'b0;
      for (int unsigned k = 0; k < MAX_PLAYER_BULLET; k++) begin
        r_PosX[k] <= NONE_X;
        r_PosY[k] <= NONE_Y;
      end
    end else if (!w_Playing) begin
      r_State    <= '0;
      r_Cooldown <= '0;
      r_FireAck  <= 1'b0;
      for (int unsigned k = 0; k < MAX_PLAYER_BULLET; k++) begin
        r_PosX[k] <= NONE_X;
        r_PosY[k] <= NONE_Y;
      end
    end else begin
      r_FireAck <= w_FireAccept;
      if (w_FireAccept)
        r_Cooldown <= COOLDOWN_FRAMES;
      else if (bus.i_FrameTick && (r_Cooldown != '0))
        r_Cooldown <= r_Cooldown - 4'd1;

      // Spawn targets an inactive slot, so it never overlaps kill/move.
      for (int unsigned k = 0; k < MAX_PLAYER_BULLET; k++) begin
        if (w_FireAccept && w_SpawnOH[k]) begin
          r_State[k] <= 1'b1;
          r_PosX[k]  <= bus.i_PlayerPosition + SPAWN_X_OFF;
          r_PosY[k]  <= SPAWN_Y;
        end else if (r_State[k]) begin
          if (bus.i_KillMask[k]) begin
            r_State[k] <= 1'b0;
            r_PosX[k]  <= NONE_X;
            r_PosY[k]  <= NONE_Y;
          end else if (bus.i_FrameTick) begin
            if (r_PosY[k] < BULLET_SPEED) begin
              r_State[k] <= 1'b0;
              r_PosX[k]  <= NONE_X;
              r_PosY[k]  <= NONE_Y;
            end else begin
              r_PosY[k] <= r_PosY[k] - BULLET_SPEED;
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_PosBus = '0;
    for (int unsigned k = 0; k < MAX_PLAYER_BULLET; k++)
      w_PosBus[19*k +: 19] = {r_PosX[k], r_PosY[k]};
  end

  assign bus.o_FireAck              = r_FireAck;
  assign bus.o_PlayerBulletState    = r_State;
  assign bus.o_PlayerBulletPosition = w_PosBus;
  assign bus.o_SlotsFull            = &r_State;

endmodule

// File: tb/tb_player_bullet_controller.sv
// Directed bench for player_bullet_controller with hand-computed expectations.
module tb_player_bullet_controller;

  localparam logic [18:0] NONE = {10'd720, 9'd500};

  logic i_Clk;
  logic i_Rst;
  int   checks;
  int   errors;

  player_bullet_controller_if #(.MAX_PLAYER_BULLET(3)) bus ();

  player_bullet_controller #(.MAX_PLAYER_BULLET(3)) u_dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [18:0] slot(input int k);
    logic [56:0] v;
    v = bus.o_PlayerBulletPosition;
    return v[19*k +: 19];
  endfunction

  function automatic logic [18:0] mk(input logic [9:0] x, input logic [8:0] y);
    return {x, y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    bus.i_FrameTick = 1'b1;
    for (int i = 0; i < n; i++) step();
    bus.i_FrameTick = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_Rst                = 1'b0;
    bus.i_GameState      = 3'b001;
    bus.i_FrameTick      = 1'b0;
    bus.i_FireReq        = 1'b0;
    bus.i_PlayerPosition = 10'd202;
    bus.i_KillMask       = 3'b000;
    step();
    step();
    chk("rst_state", bus.o_PlayerBulletState, 3'b000);
    chk("rst_pos0", slot(0), NONE);
    chk("rst_pos1", slot(1), NONE);
    chk("rst_pos2", slot(2), NONE);
    chk("rst_ack", bus.o_FireAck, 1'b0);
    chk("rst_full", bus.o_SlotsFull, 1'b0);
    i_Rst = 1'b1;
    step();

    // First shot
    bus.i_FireReq = 1'b1;
    step();
    bus.i_FireReq = 1'b0;
    chk("fire0_state", bus.o_PlayerBulletState, 3'b001);
    chk("fire0_pos", slot(0), mk(10'd212, 9'd356));
    chk("fire0_ack", bus.o_FireAck, 1'b1);
    step();
    chk("fire0_ack_pulse", bus.o_FireAck, 1'b0);

    // Movement and cooldown refusal
    ticks(3);
    chk("move3_pos", slot(0), mk(10'd212, 9'd344));
    bus.i_FireReq = 1'b1;
    step();
    chk("cd5_noack", bus.o_FireAck, 1'b0);
    chk("cd5_state", bus.o_PlayerBulletState, 3'b001);
    ticks(4);
    chk("cd1_noack", bus.o_FireAck, 1'b0);
    chk("move7_pos", slot(0), mk(10'd212, 9'd328));
    ticks(1);
    chk("cd0_tick_noack", bus.o_FireAck, 1'b0);
    chk("move8_pos", slot(0), mk(10'd212, 9'd324));
    step();
    chk("fire1_ack", bus.o_FireAck, 1'b1);
    chk("fire1_state", bus.o_PlayerBulletState, 3'b011);
    chk("fire1_pos", slot(1), mk(10'd212, 9'd356));

    // Held request fills slot 2
    ticks(8);
    chk("hold_noack", bus.o_FireAck, 1'b0);
    chk("hold_state", bus.o_PlayerBulletState, 3'b011);
    ticks(1);
    chk("fire2_ack", bus.o_FireAck, 1'b1);
    chk("fire2_state", bus.o_PlayerBulletState, 3'b111);
    chk("fire2_full", bus.o_SlotsFull, 1'b1);
    chk("fire2_pos2", slot(2), mk(10'd212, 9'd356));
    chk("fire2_pos0", slot(0), mk(10'd212, 9'd288));
    chk("fire2_pos1", slot(1), mk(10'd212, 9'd320));
    bus.i_FrameTick = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("full_noack", bus.o_FireAck, 1'b0);
    end
    bus.i_FrameTick = 1'b0;
    chk("full_state", bus.o_PlayerBulletState, 3'b111);
    chk("full_pos0", slot(0), mk(10'd212, 9'd252));
    chk("full_pos1", slot(1), mk(10'd212, 9'd284));
    chk("full_pos2", slot(2), mk(10'd212, 9'd320));

    // Kill slot 1, refire lands there
    bus.i_FireReq  = 1'b0;
    bus.i_KillMask = 3'b010;
    step();
    bus.i_KillMask = 3'b000;
    chk("kill1_pos", slot(1), NONE);
    chk("kill1_state", bus.o_PlayerBulletState, 3'b101);
    chk("kill1_full", bus.o_SlotsFull, 1'b0);
    bus.i_PlayerPosition = 10'd300;
    bus.i_FireReq = 1'b1;
    step();
    bus.i_FireReq = 1'b0;
    chk("refire1_ack", bus.o_FireAck, 1'b1);
    chk("refire1_pos", slot(1), mk(10'd310, 9'd356));
    chk("refire1_state", bus.o_PlayerBulletState, 3'b111);

    // Top border
    ticks(62);
    chk("border4_pos", slot(0), mk(10'd212, 9'd4));
    ticks(1);
    chk("border0_pos", slot(0), mk(10'd212, 9'd0));
    chk("border0_state", bus.o_PlayerBulletState, 3'b111);
    ticks(1);
    chk("retire_pos", slot(0), NONE);
    chk("retire_state", bus.o_PlayerBulletState, 3'b110);
    chk("retire_pos1", slot(1), mk(10'd310, 9'd100));
    chk("retire_pos2", slot(2), mk(10'd212, 9'd64));

    // Kill + tick + fire on the same edge
    bus.i_FireReq = 1'b1;
    step();
    bus.i_FireReq = 1'b0;
    chk("fire0b_pos", slot(0), mk(10'd310, 9'd356));
    ticks(8);
    bus.i_KillMask  = 3'b001;
    bus.i_FrameTick = 1'b1;
    bus.i_FireReq   = 1'b1;
    step();
    bus.i_KillMask = 3'b000;
    chk("same_noack", bus.o_FireAck, 1'b0);
    chk("same_pos0", slot(0), NONE);
    chk("same_state", bus.o_PlayerBulletState, 3'b110);
    chk("same_pos2", slot(2), mk(10'd212, 9'd28));
    step();
    bus.i_FrameTick = 1'b0;
    bus.i_FireReq   = 1'b0;
    chk("next_ack", bus.o_FireAck, 1'b1);
    chk("next_pos0", slot(0), mk(10'd310, 9'd356));
    chk("next_pos1", slot(1), mk(10'd310, 9'd60));
    chk("next_state", bus.o_PlayerBulletState, 3'b111);

    // Leave the playing state
    bus.i_GameState = 3'b010;
    bus.i_FireReq   = 1'b1;
    bus.i_FrameTick = 1'b1;
    step();
    chk("defeat_state", bus.o_PlayerBulletState, 3'b000);
    chk("defeat_pos0", slot(0), NONE);
    chk("defeat_pos1", slot(1), NONE);
    chk("defeat_pos2", slot(2), NONE);
    step();
    chk("defeat_ack", bus.o_FireAck, 1'b0);
    chk("defeat_hold", bus.o_PlayerBulletState, 3'b000);
    bus.i_FrameTick = 1'b0;
    bus.i_GameState = 3'b001;
    step();
    bus.i_FireReq = 1'b0;
    chk("replay_ack", bus.o_FireAck, 1'b1);
    chk("replay_pos0", slot(0), mk(10'd310, 9'd356));

    // Asynchronous reset mid-cycle
    i_Rst = 1'b0;
    #2;
    chk("async_state", bus.o_PlayerBulletState, 3'b000);
    chk("async_pos0", slot(0), NONE);
    chk("async_ack", bus.o_FireAck, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
